// File: rtl/delay_line_prog_if.sv
// Bundles the control, sample and status signals of the programmable delay line.
// The master drives control and input samples; the slave returns the delayed stream and status.
interface delay_line_prog_if #(
   parameter int WIDTH     = 8,
   parameter int MAX_DELAY = 16
);
   localparam int DW = $clog2(MAX_DELAY + 1);

   logic             en;
   logic             flush;
   logic             cfg_load;
   logic [DW-1:0]    cfg_delay;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [DW-1:0]    cur_delay;
   logic             busy;
   logic             cfg_err;

   modport master (
      output en, flush, cfg_load, cfg_delay, in_valid, in_data,
      input  out_valid, out_data, cur_delay, busy, cfg_err
   );

   modport slave (
      input  en, flush, cfg_load, cfg_delay, in_valid, in_data,
      output out_valid, out_data, cur_delay, busy, cfg_err
   );
endinterface

// File: rtl/delay_line_prog.sv
// Runtime-programmable delay line: a WIDTH-bit sample plus valid delayed by 1..MAX_DELAY enabled
// cycles, tapped out of a fixed MAX_DELAY-stage shift register.
module delay_line_prog #(
   parameter int WIDTH         = 8,
   parameter int MAX_DELAY     = 16,
   parameter int DEFAULT_DELAY = 6
) (
   input logic              clk,
   input logic              rst_n,
   delay_line_prog_if.slave bus
);
   localparam int DW = $clog2(MAX_DELAY + 1);

   logic [WIDTH-1:0]     data_q [MAX_DELAY];
   logic [MAX_DELAY-1:0] vld_q;
   logic [DW-1:0]        cur_delay_q, cur_delay_d;
   logic [DW-1:0]        fill_q, fill_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 clear;
   logic                 tap_vld;
   logic [WIDTH-1:0]     tap_data;

   function automatic logic out_of_range(input logic [DW-1:0] d);
      return (d == '0) || (d > DW'(MAX_DELAY));
   endfunction

   function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
      if (d == '0) return DW'(1);
      if (d > DW'(MAX_DELAY)) return DW'(MAX_DELAY);
      return d;
   endfunction

   // A load is a flush plus a new delay; either one overrides a shift on the same edge.
   assign clear = bus.flush | bus.cfg_load;

   always_comb begin
      cur_delay_d = cur_delay_q;
      cfg_err_d   = 1'b0;
      fill_d      = fill_q;
      if (bus.cfg_load) begin
         cur_delay_d = clamp_delay(bus.cfg_delay);
         cfg_err_d   = out_of_range(bus.cfg_delay);
      end
      if (clear) begin
         fill_d = '0;
      end else if (bus.en && (fill_q < cur_delay_q)) begin
         fill_d = fill_q + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_delay_q <= DW'(DEFAULT_DELAY);
         fill_q      <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         cur_delay_q <= cur_delay_d;
         fill_q      <= fill_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Clearing drops valid bits only; stale data stays but is masked at the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < MAX_DELAY; i++) data_q[i] <= '0;
      end else if (clear) begin
         vld_q <= '0;
      end else if (bus.en) begin
         vld_q[0]  <= bus.in_valid;
         data_q[0] <= bus.in_data;
         for (int i = 1; i < MAX_DELAY; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   always_comb begin
      tap_vld  = 1'b0;
      tap_data = '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
         if (cur_delay_q == DW'(i + 1)) begin
            tap_vld  = vld_q[i];
            tap_data = data_q[i];
         end
      end
   end

   assign bus.out_valid = tap_vld;
   assign bus.out_data  = tap_vld ? tap_data : '0;
   assign bus.cur_delay = cur_delay_q;
   assign bus.busy      = (fill_q < cur_delay_q);
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_delay_line_prog.sv
// Directed bench for delay_line_prog: vector table for single-edge behaviour, plus sequences for
// reset, stall, and a flushed stream checked against a timing scoreboard.
module tb_delay_line_prog;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   delay_line_prog_if #(.WIDTH(8), .MAX_DELAY(16)) bus ();

   delay_line_prog #(.WIDTH(8), .MAX_DELAY(16), .DEFAULT_DELAY(6)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, fl, ld;
      logic [4:0] cfg;
      logic       iv;
      logic [7:0] id;
      logic       ov;
      logic [7:0] od;
      logic [4:0] cur;
      logic       busy, err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic en, logic fl, logic ld, logic [4:0] cfg, logic iv,
                               logic [7:0] id, logic ov, logic [7:0] od, logic [4:0] cur,
                               logic busy, logic err);
      vec_t v;
      v.en = en; v.fl = fl; v.ld = ld; v.cfg = cfg; v.iv = iv; v.id = id;
      v.ov = ov; v.od = od; v.cur = cur; v.busy = busy; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.en = 1'b0; bus.flush = 1'b0; bus.cfg_load = 1'b0; bus.cfg_delay = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // T6 scoreboard state
   logic [7:0] q_val[$];
   int         q_due[$];
   int         s, n_exp, n_rx;
   bit         flushed, ev;
   logic [7:0] ed;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      tbl.push_back(mk(1,0,0, 0,1,8'hA5, 0,8'h00, 6,1,0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0, 0,0,8'hFF, 0,8'h00, 6,1,0));
      tbl.push_back(mk(1,0,0, 0,0,8'hFF, 1,8'hA5, 6,0,0));
      tbl.push_back(mk(1,0,0, 0,0,8'hFF, 0,8'h00, 6,0,0));
      tbl.push_back(mk(0,0,1, 0,0,8'h00, 0,8'h00, 1,1,1));
      tbl.push_back(mk(1,0,0, 0,1,8'h5A, 1,8'h5A, 1,0,0));
      tbl.push_back(mk(0,0,0, 0,1,8'h77, 1,8'h5A, 1,0,0));
      tbl.push_back(mk(0,0,1,31,0,8'h00, 0,8'h00,16,1,1));
      tbl.push_back(mk(1,0,0, 0,1,8'h21, 0,8'h00,16,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h22, 0,8'h00,16,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h23, 0,8'h00,16,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h24, 0,8'h00,16,1,0));
      tbl.push_back(mk(1,0,1, 3,1,8'h11, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h3C, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h44, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h55, 1,8'h3C, 3,0,0));
      tbl.push_back(mk(0,1,0, 0,0,8'h00, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,1,0, 0,1,8'h66, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h66, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h77, 0,8'h00, 3,1,0));
      tbl.push_back(mk(1,0,0, 0,1,8'h88, 1,8'h66, 3,0,0));
      tbl.push_back(mk(1,0,0, 0,0,8'h99, 1,8'h77, 3,0,0));

      reset_dut();
      #1;
      chk("rst_ov",   bus.out_valid, 0);
      chk("rst_od",   bus.out_data,  0);
      chk("rst_cur",  bus.cur_delay, 6);
      chk("rst_busy", bus.busy,      1);
      chk("rst_err",  bus.cfg_err,   0);

      // Table: T2 latency, T5 clamp, T4 reload with in-flight samples, flush behaviour
      foreach (tbl[r]) begin
         bus.en = tbl[r].en; bus.flush = tbl[r].fl; bus.cfg_load = tbl[r].ld;
         bus.cfg_delay = tbl[r].cfg; bus.in_valid = tbl[r].iv; bus.in_data = tbl[r].id;
         step();
         chk($sformatf("v%0d_ov", r),   bus.out_valid, tbl[r].ov);
         chk($sformatf("v%0d_od", r),   bus.out_data,  tbl[r].od);
         chk($sformatf("v%0d_cur", r),  bus.cur_delay, tbl[r].cur);
         chk($sformatf("v%0d_busy", r), bus.busy,      tbl[r].busy);
         chk($sformatf("v%0d_err", r),  bus.cfg_err,   tbl[r].err);
      end

      // T1: asynchronous reset while a valid sample sits on the output
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("t1_ov",   bus.out_valid, 0);
      chk("t1_od",   bus.out_data,  0);
      chk("t1_cur",  bus.cur_delay, 6);
      chk("t1_busy", bus.busy,      1);
      chk("t1_err",  bus.cfg_err,   0);
      @(negedge clk);
      rst_n = 1'b1;

      // T3: two samples, en low for 3 cycles mid-flight; outputs at cycles 8 and 9
      reset_dut();
      for (int c = 0; c < 12; c++) begin
         bus.en       = !(c >= 4 && c <= 6);
         bus.in_valid = (c == 0) || (c == 1);
         bus.in_data  = (c == 0) ? 8'hA5 : (c == 1) ? 8'h6B : 8'($urandom_range(0, 255));
         step();
         chk($sformatf("t3_c%0d_ov", c), bus.out_valid, (c == 8) || (c == 9));
         chk($sformatf("t3_c%0d_od", c), bus.out_data,
             (c == 8) ? 32'hA5 : (c == 9) ? 32'h6B : 32'h0);
      end

      // T6: stream 0..19 with random bubbles, flush presented with sample 10
      reset_dut();
      s = 0; flushed = 0; n_exp = 0; n_rx = 0;
      for (int c = 0; c < 80; c++) begin
         bus.en = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
         bus.in_data = 8'($urandom_range(0, 255));
         if (s < 20) begin
            if (s == 10 && !flushed) begin
               bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'(s);
               flushed = 1; s++;
            end else if ($urandom_range(0, 3) != 0) begin
               bus.in_valid = 1'b1; bus.in_data = 8'(s);
               q_val.push_back(8'(s)); q_due.push_back(c + 5);
               s++;
            end
         end
         step();
         if (bus.flush) begin
            while (q_due.size() > 0 && q_due[q_due.size()-1] >= c) begin
               void'(q_due.pop_back());
               void'(q_val.pop_back());
            end
         end
         ev = 0; ed = 8'h00;
         if (q_due.size() > 0 && q_due[0] == c) begin
            ev = 1; ed = q_val.pop_front();
            void'(q_due.pop_front());
            n_exp++;
         end
         if (bus.out_valid) n_rx++;
         chk($sformatf("t6_c%0d_ov", c), bus.out_valid, ev);
         chk($sformatf("t6_c%0d_od", c), bus.out_data,  ed);
      end
      chk("t6_done",  (s == 20) && (q_due.size() == 0), 1);
      chk("t6_count", n_rx, n_exp);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
